mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-requester arbiter/sequencer for the shared 32-bit main-memory address/write-data path. Port 0 is the I-cache fill engine; port 1 is the D-cache miss/writeback engine. The block grants one requester at a time, drives `mem_sel` into the shared 32-bit 2:1 address and write-data muxes, and counts burst beats against memory `mem_ready`. Priority is round-robin between requesters.

Parameters:
- BURST_LEN, 4, beats per granted transaction (1..16).
- BEAT_W, 4, width of beat counter; must satisfy 2^BEAT_W >= BURST_LEN.
- TIMEOUT_CYC, 64, cycles without `mem_ready` before abort. Used only with the optional feature.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  port 0 request; held until done0/err0.
- we0  in  1  port 0 write enable; stable while req0 is held.
- req1  in  1  port 1 request.
- we1  in  1  port 1 write enable.
- gnt0  out  1  port 0 owns the memory path.
- gnt1  out  1  port 1 owns the memory path.
- done0  out  1  one-cycle pulse on port 0 final beat.
- done1  out  1  one-cycle pulse on port 1 final beat.
- err0  out  1  port 0 timeout abort pulse (0 without feature).
- err1  out  1  port 1 timeout abort pulse (0 without feature).
- mem_sel  out  1  select for the shared addr/wdata muxes; 0 = port 0, 1 = port 1.
- mem_valid  out  1  memory transaction active.
- mem_we  out  1  write enable of the current owner.
- mem_beat  out  BEAT_W  current beat index, used as address offset.
- mem_ready  in  1  memory accepted/returned the current beat.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: FSM=IDLE, gnt0=gnt1=0, mem_valid=0, mem_sel=0, mem_we=0, mem_beat=0, last_owner=1 (so port 0 wins the first tie). All done/err outputs are 0.
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - If only reqX is high, go to BUSYX.
  - If both are high, go to BUSY(~last_owner).
  - If neither is high, stay in IDLE.
  - The decision is registered: req at cycle t gives gnt at t+1.
- BUSYX:
  - gntX=1, mem_valid=1, mem_sel=X, mem_we=weX. These are registered from state.
  - Each cycle with mem_ready=1, mem_beat increments.
  - With mem_ready=0, all state holds.
- Completion:
  - When mem_ready=1 and mem_beat==BURST_LEN-1, doneX pulses in that same cycle (combinational from state, counter and mem_ready).
  - Next state is IDLE; mem_beat is cleared to 0 and last_owner is set to X.
- Turnaround: one mandatory IDLE cycle between grants, so gnt0 and gnt1 are never both high and never switch in the same edge.
- mem_sel holds its last value in IDLE, so the mux select does not toggle without a grant.
- mem_we is 0 in IDLE.
- BURST_LEN=1: done pulses on the first mem_ready.
- Requester dropping reqX mid-burst: ignored. The burst runs to completion; reqX must stay high until done.
- New request arriving during BUSY: waits. It is evaluated in the next IDLE cycle.
- Reset mid-burst: on the next edge everything returns to reset values. No done/err pulse is produced.
- mem_beat wraps only via explicit clear at completion; it never counts past BURST_LEN-1.

Optional Feature:
Macro: MEM_PORT_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter clears on grant and on every mem_ready=1, and increments otherwise in BUSY.
  - When it reaches TIMEOUT_CYC-1 with mem_ready=0, errX pulses for one cycle and doneX stays 0.
  - Next state is IDLE, mem_beat is cleared, and last_owner is set to X.
- Undefined: no stall counter; err0=err1=0 constantly; a grant waits forever for mem_ready.

Decomposition:
- Shared package/include holds the FSM state encodings (IDLE=2'b00, BUSY0=2'b01, BUSY1=2'b10) and the default BURST_LEN/TIMEOUT_CYC constants.
- One sub-module, arb_rr_pick: combinational round-robin pick.
  - Inputs: req0, req1, last_owner.
  - Outputs: pick_valid, pick_id.
  - Reused by the later bus-arbiter blocks.
- The FSM, beat counter and stall counter stay in mem_port_arbiter.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with req0=req1=1 -> all outputs 0, mem_sel=0. Release -> gnt0=1 one cycle later.
2. Single burst: BURST_LEN=4, req0=1 at cycle 0, mem_ready=1 always, we0=1 -> gnt0 and mem_we=1 in cycles 1–4; mem_beat=0,1,2,3; done0 at cycle 4; gnt0=0 at cycle 5.
3. Round-robin: req0=req1=1 held -> grant order 0,1,0. A one-cycle IDLE gap precedes each grant; mem_sel toggles only at grant start.
4. Stalls: BURST_LEN=4, mem_ready pattern 1,0,0,1,1,1 -> mem_beat advances only on ready cycles; done asserts on the 4th ready (6th busy cycle).
5. Mid-burst reset: rst_n=0 at mem_beat=2 -> next cycle IDLE, mem_valid=0, mem_beat=0, no done0.
6. Timeout (macro defined, TIMEOUT_CYC=8): gnt1 with mem_ready=0 held -> err1 on the 8th busy cycle, done1=0. Next cycle gnt1=0. A pending req0 is granted after one IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter: FSM state encodings,
// default burst/timeout constants and a small state-decode helper.
// The optional stall timeout is enabled with MEM_PORT_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY0 = 2'b01,
        ST_BUSY1 = 2'b10
    } arb_state_e;

    localparam int BURST_LEN_DEF   = 4;
    localparam int BEAT_W_DEF      = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Requester id that owns the path in a BUSY state (1 only for BUSY1).
    function automatic logic owner_of(input arb_state_e s);
        if (s == ST_BUSY1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr_pick.sv
// Combinational two-way round-robin pick. On a tie the requester that did
// not own the path last wins; a lone requester always wins.
module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic pick_valid,
    output logic pick_id
);

    // Choose the winner among the active requests.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = 1'b0;
        if (req0 && req1) begin
            pick_valid = 1'b1;
            pick_id    = ~last_owner;
        end else if (req1) begin
            pick_valid = 1'b1;
            pick_id    = 1'b1;
        end else if (req0) begin
            pick_valid = 1'b1;
            pick_id    = 1'b0;
        end else begin
            pick_valid = 1'b0;
            pick_id    = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester main-memory port arbiter/sequencer. Grants one port at a
// time with round-robin priority, drives the shared addr/wdata mux select
// and counts burst beats against mem_ready. A mandatory IDLE cycle
// separates consecutive grants.
// Optional feature: define MEM_PORT_ARB_TIMEOUT_EN to abort a burst with an
// err pulse after TIMEOUT_CYC cycles without mem_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int BEAT_W      = BEAT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic              req1,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic              mem_sel,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [BEAT_W-1:0] mem_beat,
    input  logic              mem_ready
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic              r_last_owner;
    logic              w_last_nxt;
    logic              w_owner;
    logic              w_pick_valid;
    logic              w_pick_id;
    logic              w_done0;
    logic              w_done1;
    logic              w_err0;
    logic              w_err1;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_mem_sel;
    logic              r_mem_valid;
    logic              r_mem_we;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int                 STALL_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};

    logic [STALL_W-1:0] r_stall;
    logic [STALL_W-1:0] w_stall_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 32'd0);
`endif

    arb_rr_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (r_last_owner),
        .pick_valid (w_pick_valid),
        .pick_id    (w_pick_id)
    );

    // Next-state, beat/stall counter and completion/abort pulse logic.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_last_nxt  = r_last_owner;
        w_owner     = owner_of(r_state);
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        w_err0      = 1'b0;
        w_err1      = 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        w_stall_nxt = r_stall;
`endif
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = BEAT_ZERO;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                w_stall_nxt = STALL_ZERO;
`endif
                if (w_pick_valid) begin
                    if (w_pick_id) begin
                        w_state_nxt = ST_BUSY1;
                    end else begin
                        w_state_nxt = ST_BUSY0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (mem_ready) begin
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    w_stall_nxt = STALL_ZERO;
`endif
                    if (r_beat == LAST_BEAT) begin
                        // Pulses are suppressed while reset is asserted.
                        w_done0     = ~w_owner & rst_n;
                        w_done1     = w_owner & rst_n;
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = BEAT_ZERO;
                        w_last_nxt  = w_owner;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_ONE;
                    end
                end else begin
`ifdef MEM_PORT_ARB_TIMEOUT_EN
                    if (r_stall == STALL_LAST) begin
                        w_err0      = ~w_owner & rst_n;
                        w_err1      = w_owner & rst_n;
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = BEAT_ZERO;
                        w_last_nxt  = w_owner;
                        w_stall_nxt = STALL_ZERO;
                    end else begin
                        w_stall_nxt = r_stall + STALL_ONE;
                    end
`else
                    w_state_nxt = r_state;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = BEAT_ZERO;
            end
        endcase
    end

    // FSM state, beat counter and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_beat       <= BEAT_ZERO;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // Stall counter: cycles in BUSY since grant or the last mem_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= STALL_ZERO;
        end else begin
            r_stall <= w_stall_nxt;
        end
    end
`endif

    // Grant and memory-control outputs registered from the next state;
    // mem_sel keeps its value through IDLE so the muxes do not toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            case (w_state_nxt)
                ST_BUSY0: begin
                    r_gnt0      <= 1'b1;
                    r_gnt1      <= 1'b0;
                    r_mem_valid <= 1'b1;
                    r_mem_sel   <= 1'b0;
                    r_mem_we    <= we0;
                end
                ST_BUSY1: begin
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b1;
                    r_mem_valid <= 1'b1;
                    r_mem_sel   <= 1'b1;
                    r_mem_we    <= we1;
                end
                default: begin
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_mem_valid <= 1'b0;
                    r_mem_sel   <= r_mem_sel;
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign mem_valid = r_mem_valid;
    assign mem_sel   = r_mem_sel;
    assign mem_we    = r_mem_we;
    assign mem_beat  = r_beat;
    assign done0     = w_done0;
    assign done1     = w_done1;
    assign err0      = w_err0;
    assign err1      = w_err1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (BURST_LEN=4, TIMEOUT_CYC=8).
// The timeout section follows MEM_PORT_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1, mem_ready;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic       mem_sel, mem_valid, mem_we;
    logic [3:0] mem_beat;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .BURST_LEN   (4),
        .BEAT_W      (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .req1      (req1),
        .we1       (we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .mem_sel   (mem_sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_beat  (mem_beat),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic sel);
        chk({tag, " gnt0"},  32'(gnt0),      32'd0);
        chk({tag, " gnt1"},  32'(gnt1),      32'd0);
        chk({tag, " valid"}, 32'(mem_valid), 32'd0);
        chk({tag, " sel"},   32'(mem_sel),   32'(sel));
        chk({tag, " we"},    32'(mem_we),    32'd0);
        chk({tag, " beat"},  32'(mem_beat),  32'd0);
        chk({tag, " done0"}, 32'(done0),     32'd0);
        chk({tag, " done1"}, 32'(done1),     32'd0);
        chk({tag, " err0"},  32'(err0),      32'd0);
        chk({tag, " err1"},  32'(err1),      32'd0);
    endtask

    task automatic check_busy(input string tag, input int id, input logic we,
                              input int beat, input logic rdy);
        chk({tag, " gnt0"},  32'(gnt0),      32'(id == 0));
        chk({tag, " gnt1"},  32'(gnt1),      32'(id == 1));
        chk({tag, " valid"}, 32'(mem_valid), 32'd1);
        chk({tag, " sel"},   32'(mem_sel),   32'(id));
        chk({tag, " we"},    32'(mem_we),    32'(we));
        chk({tag, " beat"},  32'(mem_beat),  32'(beat));
        chk({tag, " done0"}, 32'(done0),     32'(id == 0 && rdy && beat == 3));
        chk({tag, " done1"}, 32'(done1),     32'(id == 1 && rdy && beat == 3));
        chk({tag, " err0"},  32'(err0),      32'd0);
        chk({tag, " err1"},  32'(err1),      32'd0);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [5:0] pat;
        int         exp_id;
        logic       prev_sel;
        int         eb;

        // Reset held with both requests high.
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        tick();
        req1 = 1'b0; mem_ready = 1'b1;
        #1;
        check_busy("rst_rel", 0, 1'b0, 0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_busy("rst_rel", 0, 1'b0, i, 1'b1);
        end
        tick();
        req0 = 1'b0;
        #1;
        check_idle("rst_rel_end", 1'b0);

        // Single write burst on port 0; req0 dropped mid-burst is ignored.
        req0 = 1'b1; we0 = 1'b1;
        #1;
        check_idle("burst_idle", 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) req0 = 1'b0;
            #1;
            check_busy("burst", 0, 1'b1, i, 1'b1);
        end
        tick();
        #1;
        check_idle("burst_end", 1'b0);

        // Round-robin with both requests held: last owner was 0, so 1,0,1.
        req0 = 1'b1; req1 = 1'b1;
        exp_id = 1;
        prev_sel = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
            check_idle("rr_gap", prev_sel);
            for (int i = 0; i < 4; i++) begin
                tick();
                #1;
                check_busy("rr", exp_id, (exp_id == 0) ? 1'b1 : 1'b0, i, 1'b1);
            end
            tick();
            prev_sel = (exp_id == 1) ? 1'b1 : 1'b0;
            exp_id = 1 - exp_id;
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check_idle("rr_end", 1'b1);

        // Stalls on port 1: ready pattern 1,0,0,1,1,1.
        req1 = 1'b1; we1 = 1'b1;
        pat = 6'b111001;
        eb = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            mem_ready = pat[c];
            #1;
            check_busy("stall", 1, 1'b1, eb, pat[c]);
            if (pat[c]) eb++;
        end
        tick();
        req1 = 1'b0; mem_ready = 1'b1;
        #1;
        check_idle("stall_end", 1'b1);

        // Reset in the middle of a port 0 burst at beat 2.
        req0 = 1'b1; we0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_busy("mrst", 0, 1'b0, i, 1'b1);
        end
        rst_n = 1'b0;
        tick();
        #1;
        check_idle("mrst_after", 1'b0);
        rst_n = 1'b1; req0 = 1'b0;
        tick();
        #1;
        check_idle("mrst_idle", 1'b0);

        // Port 1 granted while memory never answers.
        req1 = 1'b1; we1 = 1'b0; mem_ready = 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 4) req0 = 1'b1;
            #1;
            chk("to gnt1",  32'(gnt1),     32'd1);
            chk("to beat",  32'(mem_beat), 32'd0);
            chk("to err1",  32'(err1),     32'(c == 8));
            chk("to done1", 32'(done1),    32'd0);
            chk("to err0",  32'(err0),     32'd0);
        end
        tick();
        req1 = 1'b0;
        #1;
        check_idle("to_gap", 1'b1);
        tick();
        #1;
        check_busy("to_req0", 0, 1'b0, 0, 1'b0);
`else
        for (int c = 1; c <= 12; c++) begin
            tick();
            #1;
            check_busy("nto_wait", 1, 1'b0, 0, 1'b0);
        end
        mem_ready = 1'b1;
        #1;
        check_busy("nto", 1, 1'b0, 0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            check_busy("nto", 1, 1'b0, i, 1'b1);
        end
        tick();
        req1 = 1'b0;
        #1;
        check_idle("nto_end", 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
